counter_updown_param: RTL and testbench
=======================================

# counter_updown_param

Parametrised up/down counter, successor to the fixed 2-bit up/down counter. Adds configurable width, programmable terminal value, wrap or saturate mode, count enable, synchronous parallel load, and sticky overflow/underflow flags. Used wherever the design needs a bounded modulo-N or clamped counter, such as timers, ring indices, or credit counters.

## Interface
- WIDTH, 4, counter width in bits (1..32)
- MAX_VAL, 2**WIDTH-1, terminal count; legal range 1..2**WIDTH-1
- WRAP, 1, 1 = wrap at limits, 0 = saturate at limits

- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  asynchronous, active-low reset; asserted when 0
- en  in  1  count enable
- mode  in  1  1 = count up, 0 = count down
- load  in  1  synchronous parallel load strobe
- din  in  WIDTH  load value
- clr_flags  in  1  synchronous clear of ovf/unf
- dout  out  WIDTH  current count
- tc  out  1  terminal-count indicator (combinational)
- ovf  out  1  sticky overflow flag
- unf  out  1  sticky underflow flag

## Operation
- Reset (reset==0, asynchronous): dout=0, ovf=0, unf=0. The counter leaves reset on the first rising edge after reset returns to 1.
- Per-edge priority:
  - load: dout <= (din > MAX_VAL) ? MAX_VAL : din. Load ignores en and mode and never sets flags.
  - else en && mode==1:
    - dout<MAX_VAL: dout+1
    - dout==MAX_VAL: WRAP ? 0 : MAX_VAL (hold), and ovf is set
  - else en && mode==0:
    - dout>0: dout-1
    - dout==0: WRAP ? MAX_VAL : 0 (hold), and unf is set
  - else: hold.
- Flags: ovf/unf are set on an attempted step past a limit, in both WRAP and saturate modes. They clear on clr_flags. If set and clear happen in the same cycle, set wins.
- tc = en && ((mode && dout==MAX_VAL) || (!mode && dout==0)). It is high in the cycle in which the next enabled edge wraps or saturates.
- Arithmetic: computed at WIDTH+1 bits internally, with no truncation artefacts. Values of dout above MAX_VAL are unreachable.
- When MAX_VAL = 2**WIDTH-1 and WRAP=1, behaviour matches a plain binary modulo-2**WIDTH up/down counter.

## Timing
- dout, ovf and unf are registered. Each changes one clk edge after the qualifying inputs are sampled.
- tc is combinational from registered dout and the current en/mode, with zero latency.
- A mode change takes effect on the next edge, with no dead cycle.
- Reset asserted mid-count forces all outputs to reset values immediately, without waiting for clk.
- Inputs must be stable around the rising clk edge. Release of reset is synchronised outside the block.

## Structure
- Package counter_pkg holds MODE_UP=1'b1 and MODE_DOWN=1'b0, plus a function for clamping a load value to MAX_VAL.
- One combinational sub-module, counter_step, is natural. It takes dout, mode, en, MAX_VAL and WRAP, and produces next_val, hit_max and hit_min.
- The top level holds the dout/flag registers, the load mux and tc.

## Test plan
All scenarios use WIDTH=4, MAX_VAL=9 unless noted.
- Reset: drive reset=0 mid-count (dout=5, ovf=1), then reset=1 → dout=0, ovf=0, unf=0 immediately and after release.
- Up wrap (WRAP=1): en=1, mode=1 from 0 for 10 edges → 1..9, 0; tc=1 while dout=9; ovf=1 after the wrap.
- Down wrap (WRAP=1): from 0, mode=0 → 9, 8, …; unf=1 after the first edge; clr_flags → unf=0 on the next edge.
- Saturate (WRAP=0): up from 8 → 9, 9, 9 with ovf=1; then down from 1 → 0, 0 with unf=1.
- Load and priority:
  - load=1, din=4'd13, en=1 → dout=9 (clamped), flags unchanged.
  - load=1, din=3 while counting → dout=3, then counting continues.
- Corner cases:
  - en=0 holds the value with tc=0.
  - clr_flags coincident with an overflow edge → ovf stays 1.
  - WIDTH=2, MAX_VAL=3: the sequence matches a plain 2-bit up/down counter.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - direction constants and load clamp helper for the up/down counter
package counter_pkg;

    localparam logic MODE_UP   = 1'b1;
    localparam logic MODE_DOWN = 1'b0;

    // Wide enough for any legal WIDTH; callers narrow the result back to WIDTH.
    function automatic logic [31:0] clamp_load(input logic [31:0] value,
                                               input logic [31:0] max_val);
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/counter_updown_param_if.sv
// rtl/counter_updown_param_if.sv - control/status bundle of the parametrised up/down counter
interface counter_updown_param_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             clr_flags;
    logic [WIDTH-1:0] dout;
    logic             tc;
    logic             ovf;
    logic             unf;

    modport master (
        output en, mode, load, din, clr_flags,
        input  dout, tc, ovf, unf
    );

    modport slave (
        input  en, mode, load, din, clr_flags,
        output dout, tc, ovf, unf
    );
endinterface

// File: rtl/counter_step.sv
// rtl/counter_step.sv - combinational next-count computation with limit detection
module counter_step
    import counter_pkg::*;
#(
    parameter int             WIDTH   = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter bit             WRAP    = 1'b1
) (
    input  logic [WIDTH-1:0] dout,
    input  logic             mode,
    input  logic             en,
    output logic [WIDTH-1:0] next_val,
    output logic             hit_max,
    output logic             hit_min
);

    logic [WIDTH:0] inc_val;
    logic [WIDTH:0] dec_val;

    always_comb begin
        inc_val  = {1'b0, dout} + {{WIDTH{1'b0}}, 1'b1};
        dec_val  = {1'b0, dout} - {{WIDTH{1'b0}}, 1'b1};
        // The extra bit keeps the limit test exact even when MAX_VAL is all ones.
        hit_max  = en && (mode == MODE_UP) && (inc_val > {1'b0, MAX_VAL});
        hit_min  = en && (mode == MODE_DOWN) && dec_val[WIDTH];
        next_val = dout;
        if (hit_max) begin
            next_val = WRAP ? '0 : MAX_VAL;
        end else if (hit_min) begin
            next_val = WRAP ? MAX_VAL : '0;
        end else if (en && (mode == MODE_UP)) begin
            next_val = inc_val[WIDTH-1:0];
        end else if (en) begin
            next_val = dec_val[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/counter_updown_param.sv
// rtl/counter_updown_param.sv - bounded up/down counter with load, wrap/saturate and sticky flags
module counter_updown_param
    import counter_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter bit               WRAP    = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    counter_updown_param_if.slave  bus
);

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] step_val;
    logic             hit_max;
    logic             hit_min;

    counter_step #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .WRAP    (WRAP)
    ) u_step (
        .dout     (dout_q),
        .mode     (bus.mode),
        .en       (bus.en),
        .next_val (step_val),
        .hit_max  (hit_max),
        .hit_min  (hit_min)
    );

    // Load overrides stepping, so a limit hit is ignored for the flags on a load edge;
    // a flag set in the same cycle as clr_flags survives.
    always_comb begin
        dout_d = bus.load ? WIDTH'(clamp_load(32'(bus.din), 32'(MAX_VAL))) : step_val;
        ovf_d  = (ovf_q && !bus.clr_flags) || (hit_max && !bus.load);
        unf_d  = (unf_q && !bus.clr_flags) || (hit_min && !bus.load);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign bus.dout = dout_q;
    assign bus.ovf  = ovf_q;
    assign bus.unf  = unf_q;
    assign bus.tc   = hit_max || hit_min;

endmodule

// File: tb/tb_counter_updown_param.sv
// tb/tb_counter_updown_param.sv - scoreboard bench for wrap, saturate and 2-bit counter variants
module tb_counter_updown_param;
    import counter_pkg::*;

    typedef struct packed {
        logic [3:0] cnt;
        logic       ovf;
        logic       unf;
    } st_t;

    typedef struct packed {
        logic       en;
        logic       mode;
        logic       load;
        logic       clr;
        logic [3:0] din;
    } stim_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    st_t  exp_q[$];
    st_t  ma, ms, mb;

    always #5 clk = ~clk;

    counter_updown_param_if #(.WIDTH(4)) ia ();
    counter_updown_param_if #(.WIDTH(4)) isat ();
    counter_updown_param_if #(.WIDTH(2)) ib ();

    counter_updown_param #(.WIDTH(4), .MAX_VAL(4'd9), .WRAP(1'b1)) u_wrap (
        .clk(clk), .reset(reset), .bus(ia.slave));
    counter_updown_param #(.WIDTH(4), .MAX_VAL(4'd9), .WRAP(1'b0)) u_sat (
        .clk(clk), .reset(reset), .bus(isat.slave));
    counter_updown_param #(.WIDTH(2), .MAX_VAL(2'd3), .WRAP(1'b1)) u_w2 (
        .clk(clk), .reset(reset), .bus(ib.slave));

    function automatic st_t model(st_t s, logic en, logic mode, logic load, logic clr,
                                  logic [3:0] din, int maxv, bit wrap);
        st_t n = s;
        if (clr) begin
            n.ovf = 1'b0;
            n.unf = 1'b0;
        end
        if (load) begin
            n.cnt = (int'(din) > maxv) ? 4'(maxv) : din;
        end else if (en && mode) begin
            if (int'(s.cnt) >= maxv) begin
                n.ovf = 1'b1;
                n.cnt = wrap ? 4'd0 : 4'(maxv);
            end else begin
                n.cnt = s.cnt + 4'd1;
            end
        end else if (en) begin
            if (s.cnt == 4'd0) begin
                n.unf = 1'b1;
                n.cnt = wrap ? 4'(maxv) : 4'd0;
            end else begin
                n.cnt = s.cnt - 4'd1;
            end
        end
        return n;
    endfunction

    function automatic logic tc_of(st_t s, logic en, logic mode, int maxv);
        return en && ((mode && int'(s.cnt) == maxv) || (!mode && s.cnt == 4'd0));
    endfunction

    task automatic idle_all();
        ia.en = 0;   ia.mode = 0;   ia.load = 0;   ia.clr_flags = 0;   ia.din = '0;
        isat.en = 0; isat.mode = 0; isat.load = 0; isat.clr_flags = 0; isat.din = '0;
        ib.en = 0;   ib.mode = 0;   ib.load = 0;   ib.clr_flags = 0;   ib.din = '0;
    endtask

    task automatic drive(input int sel, input stim_t s);
        idle_all();
        case (sel)
            0: begin
                ia.en = s.en; ia.mode = s.mode; ia.load = s.load; ia.clr_flags = s.clr; ia.din = s.din;
                ma = model(ma, s.en, s.mode, s.load, s.clr, s.din, 9, 1'b1);
                exp_q.push_back(ma);
            end
            1: begin
                isat.en = s.en; isat.mode = s.mode; isat.load = s.load; isat.clr_flags = s.clr; isat.din = s.din;
                ms = model(ms, s.en, s.mode, s.load, s.clr, s.din, 9, 1'b0);
                exp_q.push_back(ms);
            end
            default: begin
                ib.en = s.en; ib.mode = s.mode; ib.load = s.load; ib.clr_flags = s.clr; ib.din = s.din[1:0];
                mb = model(mb, s.en, s.mode, s.load, s.clr, s.din, 3, 1'b1);
                exp_q.push_back(mb);
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        st_t e;
        st_t got;
        reset = 1'b0;
        idle_all();
        #1;
        total++;
        if ({ia.dout, ia.ovf, ia.unf, isat.dout, isat.ovf, isat.unf, ib.dout, ib.ovf, ib.unf} !== 16'h0) begin
            bad++;
            $display("FAIL reset_initial got a=%0d/%b%b s=%0d b=%0d need all zero", ia.dout, ia.ovf, ia.unf, isat.dout, ib.dout);
        end
        @(negedge clk);
        reset = 1'b1;
        ma = '0; ms = '0; mb = '0;
        drive(0, '{1'b0, MODE_UP, 1'b1, 1'b0, 4'd9});
        for (int i = 0; i < 7; i++) begin
            tick();
            e = exp_q.pop_front();
            got = {ia.dout, ia.ovf, ia.unf};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL reset_prep[%0d] got=%b need=%b", i, got, e);
            end
            drive(0, '{1'b1, MODE_UP, 1'b0, 1'b0, 4'd0});
        end
        idle_all();
        void'(exp_q.pop_back());
        ma = model(ma, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 9, 1'b1);
        total++;
        if ({ia.dout, ia.ovf} !== {4'd5, 1'b1}) begin
            bad++;
            $display("FAIL reset_midcount_setup got=%0d ovf=%b need=5 ovf=1", ia.dout, ia.ovf);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({ia.dout, ia.ovf, ia.unf} !== 6'b0) begin
            bad++;
            $display("FAIL reset_async got=%0d/%b%b need 0/00", ia.dout, ia.ovf, ia.unf);
        end
        @(negedge clk);
        reset = 1'b1;
        ma = '0; ms = '0; mb = '0;
        exp_q.delete();
        tick();
        total++;
        if ({ia.dout, ia.ovf, ia.unf} !== 6'b0) begin
            bad++;
            $display("FAIL reset_release got=%0d/%b%b need 0/00", ia.dout, ia.ovf, ia.unf);
        end
    endtask

    task automatic test_up_wrap();
        st_t  e;
        st_t  got;
        logic exp_tc;
        for (int i = 0; i < 10; i++) begin
            exp_tc = tc_of(ma, 1'b1, MODE_UP, 9);
            drive(0, '{1'b1, MODE_UP, 1'b0, 1'b0, 4'd0});
            #1;
            total++;
            if (ia.tc !== exp_tc) begin
                bad++;
                $display("FAIL up_wrap_tc[%0d] got=%b need=%b", i, ia.tc, exp_tc);
            end
            tick();
            e = exp_q.pop_front();
            got = {ia.dout, ia.ovf, ia.unf};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL up_wrap[%0d] got=%b need=%b", i, got, e);
            end
        end
    endtask

    task automatic run_table(input string name, input int sel, input stim_t tbl[]);
        st_t  e;
        st_t  got;
        st_t  cur;
        logic exp_tc;
        logic got_tc;
        foreach (tbl[i]) begin
            cur = (sel == 0) ? ma : (sel == 1) ? ms : mb;
            exp_tc = tc_of(cur, tbl[i].en, tbl[i].mode, (sel == 2) ? 3 : 9);
            drive(sel, tbl[i]);
            #1;
            got_tc = (sel == 0) ? ia.tc : (sel == 1) ? isat.tc : ib.tc;
            total++;
            if (got_tc !== exp_tc) begin
                bad++;
                $display("FAIL %s_tc[%0d] got=%b need=%b", name, i, got_tc, exp_tc);
            end
            tick();
            e = exp_q.pop_front();
            got = (sel == 0) ? {ia.dout, ia.ovf, ia.unf} :
                  (sel == 1) ? {isat.dout, isat.ovf, isat.unf} :
                               {2'b00, ib.dout, ib.ovf, ib.unf};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL %s[%0d] got=%b need=%b", name, i, got, e);
            end
        end
    endtask

    task automatic test_down_wrap();
        stim_t tbl[] = '{
            '{1'b1, MODE_DOWN, 1'b0, 1'b0, 4'd0},
            '{1'b1, MODE_DOWN, 1'b0, 1'b0, 4'd0},
            '{1'b1, MODE_DOWN, 1'b0, 1'b0, 4'd0},
            '{1'b0, MODE_DOWN, 1'b0, 1'b1, 4'd0}
        };
        run_table("down_wrap", 0, tbl);
    endtask

    task automatic test_saturate();
        stim_t tbl[] = '{
            '{1'b0, MODE_UP,   1'b1, 1'b0, 4'd8},
            '{1'b1, MODE_UP,   1'b0, 1'b0, 4'd0},
            '{1'b1, MODE_UP,   1'b0, 1'b0, 4'd0},
            '{1'b1, MODE_UP,   1'b0, 1'b0, 4'd0},
            '{1'b0, MODE_DOWN, 1'b1, 1'b0, 4'd1},
            '{1'b1, MODE_DOWN, 1'b0, 1'b0, 4'd0},
            '{1'b1, MODE_DOWN, 1'b0, 1'b0, 4'd0}
        };
        run_table("saturate", 1, tbl);
    endtask

    task automatic test_load();
        stim_t tbl[] = '{
            '{1'b1, MODE_UP, 1'b1, 1'b0, 4'd13},
            '{1'b1, MODE_UP, 1'b1, 1'b0, 4'd13},
            '{1'b1, MODE_UP, 1'b0, 1'b0, 4'd0},
            '{1'b1, MODE_UP, 1'b1, 1'b0, 4'd3},
            '{1'b1, MODE_UP, 1'b0, 1'b0, 4'd0},
            '{1'b1, MODE_UP, 1'b0, 1'b0, 4'd0}
        };
        run_table("load", 0, tbl);
    endtask

    task automatic test_corners();
        stim_t tbl[] = '{
            '{1'b0, MODE_UP, 1'b1, 1'b0, 4'd9},
            '{1'b0, MODE_UP, 1'b0, 1'b1, 4'd0},
            '{1'b0, MODE_UP, 1'b0, 1'b0, 4'd0},
            '{1'b0, MODE_DOWN, 1'b0, 1'b0, 4'd0},
            '{1'b1, MODE_UP, 1'b0, 1'b1, 4'd0},
            '{1'b1, MODE_DOWN, 1'b0, 1'b0, 4'd0}
        };
        run_table("corner", 0, tbl);
    endtask

    task automatic test_w2();
        stim_t tbl[] = new[24];
        foreach (tbl[i]) begin
            tbl[i] = '{1'b1, (i < 6) ? MODE_UP : (i < 12) ? MODE_DOWN : logic'($urandom_range(1, 0)),
                       1'b0, 1'b0, 4'd0};
        end
        run_table("w2", 2, tbl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_load();
        test_corners();
        test_w2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
